sev_seg_scan_mux: RTL and testbench

- Time-multiplexed 4-digit scanner; sits directly upstream of sev_seg_display.
- Holds a 16-bit hex value, rotates through its four nibbles, and drives one nibble per slot on digit_nibble. digit_nibble connects to in_num of sev_seg_display.
- Drives the matching active-low anode enable, with a short anti-ghost blanking gap at the start of each slot.
- New values are applied only at frame boundaries, so a digit never shows a mix of old and new values.

---
 rtl/sev_seg_pkg.sv | 28 ++
 rtl/sev_seg_prescaler.sv | 49 ++++
 rtl/sev_seg_scan_mux.sv | 134 +++++++++++++
 tb/tb_sev_seg_scan_mux.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sev_seg_pkg.sv
// ---------------------------------------------------------------------------
// sev_seg_pkg
//   Definitions shared by the seven-segment display blocks (scan mux and
//   segment decoder).
//
//   NUM_DIGITS  : number of multiplexed digits on the display
//   DIGIT_W     : width of one hex digit
//   AN_OFF      : anode pattern with every digit dark (anodes are active-low)
//   digit_idx_t : index of the digit currently being scanned
//   an_select() : active-low one-hot anode pattern for a digit index
// ---------------------------------------------------------------------------
package sev_seg_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int DIGIT_W    = 4;

    localparam logic [NUM_DIGITS-1:0] AN_OFF = 4'b1111;

    typedef logic [1:0] digit_idx_t;

    // Drive only the selected digit's anode low.
    function automatic logic [NUM_DIGITS-1:0] an_select(input digit_idx_t idx);
        logic [NUM_DIGITS-1:0] one_hot;
        one_hot = 4'b0001 << idx;
        return ~one_hot;
    endfunction

endpackage

// File: rtl/sev_seg_prescaler.sv
// ---------------------------------------------------------------------------
// sev_seg_prescaler
//   Free-running modulo-SCAN_DIV counter used to time display slots.
//   Counts 0 .. SCAN_DIV-1 and wraps; tc is high (combinationally) for the
//   whole terminal cycle, i.e. while count == SCAN_DIV-1.
//
//   Parameters
//     SCAN_DIV : counter modulus (clock cycles per slot)
//     CNT_W    : counter width, 2**CNT_W >= SCAN_DIV
//
//   Ports
//     clk   in   clock, rising edge
//     rst   in   synchronous active-high reset, clears the count
//     count out  current count value
//     tc    out  terminal-count flag
// ---------------------------------------------------------------------------
module sev_seg_prescaler #(
    parameter int SCAN_DIV = 50000,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    output logic [CNT_W-1:0] count,
    output logic             tc
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(SCAN_DIV - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             tc_d;

    always_comb begin
        tc_d    = (count_q == LAST);
        count_d = tc_d ? '0 : count_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign tc    = tc_d;

endmodule

// File: rtl/sev_seg_scan_mux.sv
// ---------------------------------------------------------------------------
// sev_seg_scan_mux
//   Time-multiplexed scanner for a 4-digit common-anode hex display. Each
//   digit owns one slot of SCAN_DIV cycles; the first BLANK_CYC cycles of
//   every slot keep all anodes off so the previous digit cannot ghost into
//   the next one. A loaded value waits in a pending register and is copied
//   into the displayed (active) register only at the end of the digit-3
//   slot, so a frame never mixes old and new digits.
//
//   Parameters
//     SCAN_DIV  : cycles per digit slot (>= 4)
//     BLANK_CYC : blanking cycles at the start of each slot (< SCAN_DIV)
//     CNT_W     : prescaler width (2**CNT_W >= SCAN_DIV)
//
//   Ports
//     clk          in   clock, rising edge
//     rst          in   synchronous active-high reset
//     load         in   one-cycle strobe capturing value
//     value        in   16-bit value, digit 0 = value[3:0]
//     blank_lz     in   1 = suppress leading zero digits
//     digit_nibble out  nibble for the current slot (to sev_seg_display)
//     an           out  active-low anode enables, an[i] = digit i
//     frame_done   out  one-cycle pulse in the first cycle of a new frame
// ---------------------------------------------------------------------------
module sev_seg_scan_mux
    import sev_seg_pkg::*;
#(
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 2,
    parameter int CNT_W     = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [15:0]             value,
    input  logic                    blank_lz,
    output logic [DIGIT_W-1:0]      digit_nibble,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);

    localparam int VAL_W = NUM_DIGITS * DIGIT_W;
    localparam digit_idx_t LAST_IDX = digit_idx_t'(NUM_DIGITS - 1);

    // Slot timing
    logic [CNT_W-1:0]       presc_q;
    logic [CNT_W-1:0]       presc_next;
    logic                   presc_tc;

    // Scan and value state
    digit_idx_t             idx_q, idx_d;
    logic [VAL_W-1:0]       pending_q, pending_d;
    logic [VAL_W-1:0]       active_q, active_d;

    // Registered outputs
    logic [DIGIT_W-1:0]     digit_nibble_q, digit_nibble_d;
    logic [NUM_DIGITS-1:0]  an_q, an_d;
    logic                   frame_done_q, frame_done_d;

    logic                   frame_end;
    logic                   suppress;
    logic [NUM_DIGITS-1:0]  upper_zero;

    sev_seg_prescaler #(
        .SCAN_DIV (SCAN_DIV),
        .CNT_W    (CNT_W)
    ) u_prescaler (
        .clk   (clk),
        .rst   (rst),
        .count (presc_q),
        .tc    (presc_tc)
    );

    // upper_zero[i]: digit i and every digit above it are zero in the value
    // that will be on display next cycle. A digit is a leading zero exactly
    // when this holds and it is not digit 0.
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_lz
            assign upper_zero[gi] = (active_d[VAL_W-1:DIGIT_W*gi] == '0);
        end
    endgenerate

    always_comb begin
        // The prescaler only exposes its current count; recompute its next
        // value so the registered outputs line up with the state they
        // describe rather than lagging it by a cycle.
        presc_next = presc_tc ? '0 : presc_q + CNT_W'(1);

        idx_d      = presc_tc ? digit_idx_t'(idx_q + 2'd1) : idx_q;
        frame_end  = presc_tc && (idx_q == LAST_IDX);

        // A load coinciding with the frame boundary bypasses pending.
        pending_d  = load ? value : pending_q;
        active_d   = active_q;
        if (frame_end) begin
            active_d = load ? value : pending_q;
        end

        digit_nibble_d = active_d[{idx_d, 2'b00} +: DIGIT_W];

        suppress = blank_lz && (idx_d != '0) && upper_zero[idx_d];

        if ((presc_next < CNT_W'(BLANK_CYC)) || suppress) begin
            an_d = AN_OFF;
        end else begin
            an_d = an_select(idx_d);
        end

        frame_done_d = frame_end;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q          <= '0;
            pending_q      <= '0;
            active_q       <= '0;
            digit_nibble_q <= '0;
            an_q           <= AN_OFF;
            frame_done_q   <= 1'b0;
        end else begin
            idx_q          <= idx_d;
            pending_q      <= pending_d;
            active_q       <= active_d;
            digit_nibble_q <= digit_nibble_d;
            an_q           <= an_d;
            frame_done_q   <= frame_done_d;
        end
    end

    assign digit_nibble = digit_nibble_q;
    assign an           = an_q;
    assign frame_done   = frame_done_q;

endmodule

// File: tb/tb_sev_seg_scan_mux.sv
// ---------------------------------------------------------------------------
// tb_sev_seg_scan_mux
//   Directed bench for sev_seg_scan_mux with SCAN_DIV=8, BLANK_CYC=2.
//   A cycle-indexed model (time since reset release, pending and displayed
//   values) predicts an / digit_nibble / frame_done every cycle; directed
//   literal expectations pin the model to hand-computed values.
// ---------------------------------------------------------------------------
module tb_sev_seg_scan_mux;

    localparam int SCAN_DIV  = 8;
    localparam int BLANK_CYC = 2;
    localparam int CNT_W     = 16;
    localparam int FRAME     = 4 * SCAN_DIV;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [15:0] value;
    logic        blank_lz;
    logic [3:0]  digit_nibble;
    logic [3:0]  an;
    logic        frame_done;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: m_t is the index of the current cycle since the last
    // reset edge (cycle 0 = first cycle with prescaler 0).
    int          m_t = 0;
    logic [15:0] m_active  = '0;
    logic [15:0] m_pending = '0;
    logic        m_fd  = 1'b0;
    logic        m_blz = 1'b0;
    bit          model_live = 1'b0;

    logic [3:0]  an_log  [FRAME];
    logic [3:0]  nib_log [FRAME];
    logic        fd_log  [FRAME];

    always #5 clk = ~clk;

    sev_seg_scan_mux #(
        .SCAN_DIV  (SCAN_DIV),
        .BLANK_CYC (BLANK_CYC),
        .CNT_W     (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .load         (load),
        .value        (value),
        .blank_lz     (blank_lz),
        .digit_nibble (digit_nibble),
        .an           (an),
        .frame_done   (frame_done)
    );

    task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (model cycle %0d)", nm, got, exp, m_t);
        end
    endtask

    // Expected outputs from the display rules, using slot/phase arithmetic.
    function automatic logic [3:0] exp_an();
        int          slot  = (m_t / SCAN_DIV) % 4;
        int          phase = m_t % SCAN_DIV;
        logic [15:0] upper = m_active >> (4 * slot);
        logic [3:0]  one   = 4'b0001;
        if (phase < BLANK_CYC) return 4'hF;
        if (m_blz && slot != 0 && upper == 16'h0) return 4'hF;
        return ~(one << slot);
    endfunction

    function automatic logic [3:0] exp_nib();
        int          slot = (m_t / SCAN_DIV) % 4;
        logic [15:0] sh   = m_active >> (4 * slot);
        return sh[3:0];
    endfunction

    // Model update on every rising edge, then a per-cycle compare.
    always @(posedge clk) begin
        if (rst) begin
            m_t        = 0;
            m_active   = '0;
            m_pending  = '0;
            m_fd       = 1'b0;
            m_blz      = blank_lz;
            model_live = 1'b1;
        end else if (model_live) begin
            m_fd = ((m_t % FRAME) == FRAME - 1);
            if (m_fd) m_active = load ? value : m_pending;
            if (load) m_pending = value;
            m_t   = m_t + 1;
            m_blz = blank_lz;
        end
        #1;
        if (model_live) begin
            chk("cyc_an",         {12'h0, an},           {12'h0, exp_an()});
            chk("cyc_nibble",     {12'h0, digit_nibble}, {12'h0, exp_nib()});
            chk("cyc_frame_done", {15'h0, frame_done},   {15'h0, m_fd});
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_until_t(input int t);
        int guard = 0;
        while (m_t != t) begin
            if (guard >= 4 * FRAME) begin
                n_checks++;
                n_fail++;
                $display("FAIL wait_cycle: stuck at %0d, target %0d", m_t, t);
                return;
            end
            tick();
            guard++;
        end
    endtask

    task automatic do_load(input logic [15:0] v);
        load  = 1'b1;
        value = v;
        $display("load value=%h at cycle %0d blank_lz=%0b", v, m_t, blank_lz);
        tick();
        load  = 1'b0;
    endtask

    task automatic capture_frame();
        for (int k = 0; k < FRAME; k++) begin
            an_log[k]  = an;
            nib_log[k] = digit_nibble;
            fd_log[k]  = frame_done;
            tick();
        end
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int low [4];
        int cnt_a;
        int cnt_b;

        rst      = 1'b1;
        load     = 1'b0;
        value    = '0;
        blank_lz = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_an_during", {12'h0, an}, 16'h000F);
        rst = 1'b0;

        // 1. Reset state and first lit anode
        chk("rst_an_c0",     {12'h0, an},           16'h000F);
        chk("rst_nib_c0",    {12'h0, digit_nibble}, 16'h0000);
        chk("rst_fd_c0",     {15'h0, frame_done},   16'h0000);
        tick();
        chk("rst_an_c1",     {12'h0, an},           16'h000F);
        tick();
        chk("first_lit_c2",  {12'h0, an},           16'h000E);

        // 2. Mid-frame load shows only from the next frame
        wait_until_t(12);
        do_load(16'h5D80);
        wait_until_t(26);
        chk("old_frame_nib", {12'h0, digit_nibble}, 16'h0000);
        chk("old_frame_an",  {12'h0, an},           16'h0007);
        wait_until_t(32);
        capture_frame();
        chk("f1_fd_first",   {15'h0, fd_log[0]},    16'h0001);
        chk("f1_d0_nib",     {12'h0, nib_log[2]},   16'h0000);
        chk("f1_d0_an",      {12'h0, an_log[2]},    16'h000E);
        chk("f1_d1_nib",     {12'h0, nib_log[10]},  16'h0008);
        chk("f1_d1_an",      {12'h0, an_log[10]},   16'h000D);
        chk("f1_d2_nib",     {12'h0, nib_log[18]},  16'h000D);
        chk("f1_d2_an",      {12'h0, an_log[18]},   16'h000B);
        chk("f1_d3_nib",     {12'h0, nib_log[26]},  16'h0005);
        chk("f1_d3_an",      {12'h0, an_log[26]},   16'h0007);
        low = '{0, 0, 0, 0};
        for (int k = 0; k < FRAME; k++)
            for (int i = 0; i < 4; i++)
                if (an_log[k][i] == 1'b0) low[i]++;
        for (int i = 0; i < 4; i++)
            chk($sformatf("f1_low_cycles_an%0d", i), 16'(low[i]), 16'd6);

        // 3. Load on the boundary cycle goes straight to display
        wait_until_t(95);
        do_load(16'h1234);
        chk("bnd_fd_96",     {15'h0, frame_done},   16'h0001);
        capture_frame();
        chk("f3_d0_nib",     {12'h0, nib_log[2]},   16'h0004);
        chk("f3_d0_an",      {12'h0, an_log[2]},    16'h000E);
        chk("f3_d1_nib",     {12'h0, nib_log[10]},  16'h0003);
        chk("f3_d2_nib",     {12'h0, nib_log[18]},  16'h0002);
        chk("f3_d3_nib",     {12'h0, nib_log[26]},  16'h0001);
        chk("f3_d3_an",      {12'h0, an_log[26]},   16'h0007);
        cnt_a = 0;
        for (int k = 0; k < FRAME; k++) if (fd_log[k]) cnt_a++;
        chk("f3_fd_count",   16'(cnt_a),            16'd1);
        chk("bnd_fd_128",    {15'h0, frame_done},   16'h0001);

        // 4. Leading-zero suppression with 0050
        blank_lz = 1'b1;
        do_load(16'h0050);
        wait_until_t(160);
        capture_frame();
        chk("lz_d0_an",      {12'h0, an_log[2]},    16'h000E);
        chk("lz_d0_nib",     {12'h0, nib_log[2]},   16'h0000);
        chk("lz_d1_an",      {12'h0, an_log[10]},   16'h000D);
        chk("lz_d1_nib",     {12'h0, nib_log[10]},  16'h0005);
        cnt_a = 0;
        cnt_b = 0;
        for (int k = 16; k < FRAME; k++) begin
            if (an_log[k] != 4'hF) cnt_a++;
            if (nib_log[k] != 4'h0) cnt_b++;
        end
        chk("lz_d23_lit",    16'(cnt_a),            16'd0);
        chk("lz_d23_nonzero",16'(cnt_b),            16'd0);

        // 5. Leading-zero suppression with 0000
        do_load(16'h0000);
        wait_until_t(224);
        capture_frame();
        chk("z_d0_an",       {12'h0, an_log[2]},    16'h000E);
        chk("z_d0_nib",      {12'h0, nib_log[2]},   16'h0000);
        cnt_a = 0;
        for (int k = 8; k < FRAME; k++) if (an_log[k] != 4'hF) cnt_a++;
        chk("z_d123_lit",    16'(cnt_a),            16'd0);

        // 6. Reset mid-slot 2 with a pending value
        wait_until_t(260);
        do_load(16'hABCD);
        wait_until_t(275);
        rst = 1'b1;
        $display("reset asserted at cycle %0d", m_t);
        tick();
        chk("mid_rst_an",    {12'h0, an},           16'h000F);
        chk("mid_rst_nib",   {12'h0, digit_nibble}, 16'h0000);
        chk("mid_rst_fd",    {15'h0, frame_done},   16'h0000);
        rst      = 1'b0;
        blank_lz = 1'b0;
        wait_until_t(10);
        chk("post_rst_d1_an",  {12'h0, an},           16'h000D);
        chk("post_rst_d1_nib", {12'h0, digit_nibble}, 16'h0000);
        wait_until_t(26);
        chk("post_rst_d3_an",  {12'h0, an},           16'h0007);
        wait_until_t(34);
        chk("post_rst_f2_an",  {12'h0, an},           16'h000E);
        chk("post_rst_f2_nib", {12'h0, digit_nibble}, 16'h0000);
        wait_until_t(42);
        chk("post_rst_f2_d1",  {12'h0, digit_nibble}, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
